value_bias_stream_loader: RTL and testbench
===========================================

# value_bias_stream_loader

Receiver and replayer for a streamed bias parameter vector, used in the attention value path. It accepts `OUT_DEPTH` beats on a valid/ready input stream and stores them in an internal register buffer. Once the buffer is full it replays the stored beats cyclically on a valid/ready output stream, so downstream linear layers see the same interface as a ROM-backed parameter source. Typical uses are run-time bias loading from a host or DMA stream, and loopback verification of the parameter-source blocks.

## Interface
- `VALUE_BIAS_TENSOR_SIZE_DIM_0`, 32: elements per bias vector.
- `VALUE_BIAS_TENSOR_SIZE_DIM_1`, 1: rows; only 1 is supported.
- `VALUE_BIAS_PRECISION_0`, 16: element width in bits.
- `VALUE_BIAS_PRECISION_1`, 3: fractional bits; informational only, no arithmetic uses it.
- `VALUE_BIAS_PARALLELISM_DIM_0`, 1: elements per beat; must divide `TENSOR_SIZE_DIM_0`.
- `VALUE_BIAS_PARALLELISM_DIM_1`, 1: rows per beat.
- `OUT_DEPTH`, `TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0`: beats per vector; must be ≥1.

Ports (P = `PARALLELISM_DIM_0*PARALLELISM_DIM_1`, W = `PRECISION_0`):
- `clk`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  [W-1:0] x P  input beat, unpacked array.
- `data_in_valid`  in  1  upstream beat valid.
- `data_in_ready`  out  1  block can accept a beat.
- `data_out`  out  [W-1:0] x P  replayed beat.
- `data_out_valid`  out  1  replay beat valid.
- `data_out_ready`  in  1  downstream accepts the beat.
- `reload`  in  1  single-cycle pulse; discards contents and restarts loading.
- `loaded`  out  1  high while the buffer holds a complete vector.

## Operation
The block has a two-state machine, LOAD and REPLAY, plus a register buffer `buf[OUT_DEPTH]` of P×W bits per entry.

LOAD state:
- `data_in_ready` = 1.
- On `data_in_valid && data_in_ready`: `buf[wr_ptr] <= data_in`, and `wr_ptr` increments.
- On the handshake where `wr_ptr == OUT_DEPTH-1`: `wr_ptr <= 0`, `rd_ptr <= 0`, and the state moves to REPLAY.
- `data_out_valid` = 0 and `loaded` = 0.

REPLAY state:
- `data_in_ready` = 0 and `loaded` = 1.
- `data_out_valid` = 1, and `data_out = buf[rd_ptr]` (combinational read).
- On `data_out_ready`: `rd_ptr` increments, wrapping from `OUT_DEPTH-1` to 0.
- The block keeps replaying the vector indefinitely.

Reload:
- `reload` in either state sets state to LOAD, `wr_ptr` to 0 and `rd_ptr` to 0 on the next edge. Buffer contents are left in place but treated as stale.
- `reload` has priority over an input handshake in the same cycle; the concurrent input beat is dropped.
- `reload` coinciding with an output handshake in REPLAY: that output beat counts as delivered, then the state moves to LOAD.

Other rules:
- `OUT_DEPTH` = 1: every input handshake completes the vector, and `rd_ptr` stays at 0.
- Pointers are `$clog2(OUT_DEPTH)+1` bits wide, so the value `OUT_DEPTH` fits.

## Timing
- Reset values: state = LOAD, `wr_ptr` = `rd_ptr` = 0, `data_in_ready` = 1, `data_out_valid` = 0, `loaded` = 0. Buffer contents are not reset.
- Load latency: the last input handshake at edge N gives `data_out_valid` = 1 and `data_out = buf[0]` after edge N.
- Replay: zero-latency read, one beat per cycle while `data_out_ready` stays high.
- `data_out_valid` and `data_in_ready` are pure functions of state (registered). There is no combinational path from `data_out_ready` to `data_in_ready`.
- After `reload` at edge N: `data_out_valid` = 0 and `data_in_ready` = 1 after edge N.
- Reset asserted mid-load or mid-replay returns the block to the reset values on the next edge.

## Configuration
- `VALUE_BIAS_LOADER_CHECKSUM_EN`, when defined:
  - Adds output `checksum` [W-1:0].
  - `checksum` is the XOR of all elements of every accepted input beat since the last `rst` or `reload`.
  - It is cleared to 0 by `rst` or `reload` and frozen in REPLAY.
- When not defined: the port and its logic are absent, and behaviour is otherwise identical.

## Structure
- A shared package `value_bias_loader_pkg` holds:
  - the state enum `loader_state_t {LOAD, REPLAY}`;
  - the pointer-width function.
- One sub-module, `value_bias_loader_buffer`: the `OUT_DEPTH`×(P·W) register array with a write port (en, addr, data) and a combinational read port (addr).

## Test plan
- **Basic load and replay:** defaults, feed beats 0x0001..0x0020 with valid held high. Expect `data_in_ready` to drop after the 32nd beat, `loaded` = 1 on the next cycle, and `data_out` to equal 0x0001..0x0020 then wrap to 0x0001.
- **Output backpressure:** in REPLAY, toggle `data_out_ready` 1,0,0,1. Expect `data_out` to hold while ready is low and advance exactly once per handshake.
- **Gapped input:** drive input valid every third cycle. Expect exactly 32 writes, no duplicated beats, and replay to match the inputs.
- **Reload mid-replay:** pulse `reload` during a replay handshake. Expect valid = 0 next cycle; reloading 0x0100..0x011F then replays the new values from index 0.
- **Reset during load:** assert `rst` after 10 beats. Expect reset values, and a full 32-beat load is required before `loaded` rises.
- **Checksum (`VALUE_BIAS_LOADER_CHECKSUM_EN` defined):** load 0x0001..0x0020. Expect `checksum` = 0x0020 in REPLAY.

Source files
------------

// File: rtl/value_bias_loader_pkg.sv
// Shared types and helpers for the value bias stream loader.
package value_bias_loader_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    REPLAY = 1'b1
  } loader_state_t;

  // Pointer width that can also hold the value depth itself.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/value_bias_loader_buffer.sv
// Register array holding one bias vector: one synchronous write port and
// one combinational read port.
module value_bias_loader_buffer #(
  parameter int DEPTH = 32,
  parameter int P     = 1,
  parameter int W     = 16,
  parameter int AW    = 6
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0] wr_data [P],
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0] rd_data [P]
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH][P];

  // Contents are intentionally not reset; stale data is never presented.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int p = 0; p < P; p++) begin
        mem[wr_addr[IW-1:0]][p] <= wr_data[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < P; p++) begin
      rd_data[p] = mem[rd_addr[IW-1:0]][p];
    end
  end

endmodule

// File: rtl/value_bias_stream_loader.sv
// Loads OUT_DEPTH beats from a valid/ready stream, then replays them forever.
// Optional checksum output enabled by VALUE_BIAS_LOADER_CHECKSUM_EN.
module value_bias_stream_loader
  import value_bias_loader_pkg::*;
#(
  parameter int VALUE_BIAS_TENSOR_SIZE_DIM_0 = 32,
  parameter int VALUE_BIAS_TENSOR_SIZE_DIM_1 = 1,
  parameter int VALUE_BIAS_PRECISION_0       = 16,
  parameter int VALUE_BIAS_PRECISION_1       = 3,
  parameter int VALUE_BIAS_PARALLELISM_DIM_0 = 1,
  parameter int VALUE_BIAS_PARALLELISM_DIM_1 = 1,
  parameter int OUT_DEPTH = VALUE_BIAS_TENSOR_SIZE_DIM_0 / VALUE_BIAS_PARALLELISM_DIM_0
) (
  input  logic clk,
  input  logic rst,
  input  logic [VALUE_BIAS_PRECISION_0-1:0]
               data_in [VALUE_BIAS_PARALLELISM_DIM_0*VALUE_BIAS_PARALLELISM_DIM_1],
  input  logic data_in_valid,
  output logic data_in_ready,
  output logic [VALUE_BIAS_PRECISION_0-1:0]
               data_out [VALUE_BIAS_PARALLELISM_DIM_0*VALUE_BIAS_PARALLELISM_DIM_1],
  output logic data_out_valid,
  input  logic data_out_ready,
  input  logic reload,
`ifdef VALUE_BIAS_LOADER_CHECKSUM_EN
  output logic [VALUE_BIAS_PRECISION_0-1:0] checksum,
`endif
  output logic loaded
);

  localparam int P  = VALUE_BIAS_PARALLELISM_DIM_0 * VALUE_BIAS_PARALLELISM_DIM_1;
  localparam int W  = VALUE_BIAS_PRECISION_0;
  localparam int PW = ptr_width(OUT_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(OUT_DEPTH - 1);

  loader_state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          in_fire, out_fire, wr_en;

  // Handshake: a beat transfers on a rising edge where valid && ready.
  // Both ready/valid outputs are decoded from the state register only.
  assign data_in_ready  = (state_q == LOAD);
  assign data_out_valid = (state_q == REPLAY);
  assign loaded         = (state_q == REPLAY);

  assign in_fire  = data_in_valid && data_in_ready;
  assign out_fire = data_out_valid && data_out_ready;
  // Reload wins over a concurrent input beat, which is dropped.
  assign wr_en    = in_fire && !reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (reload) begin
      state_d  = LOAD;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_fire) begin
            if (wr_ptr_q == LAST) begin
              state_d  = REPLAY;
              wr_ptr_d = '0;
              rd_ptr_d = '0;
            end else begin
              wr_ptr_d = wr_ptr_q + PW'(1);
            end
          end
        end
        REPLAY: begin
          if (out_fire) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  value_bias_loader_buffer #(
    .DEPTH (OUT_DEPTH),
    .P     (P),
    .W     (W),
    .AW    (PW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

`ifdef VALUE_BIAS_LOADER_CHECKSUM_EN
  logic [W-1:0] beat_xor;
  logic [W-1:0] checksum_q;

  always_comb begin
    beat_xor = '0;
    for (int p = 0; p < P; p++) begin
      beat_xor = beat_xor ^ data_in[p];
    end
  end

  // Only accepted beats contribute, so the value freezes in REPLAY.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      checksum_q <= '0;
    end else if (wr_en) begin
      checksum_q <= checksum_q ^ beat_xor;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_value_bias_stream_loader.sv
// Self-checking bench for value_bias_stream_loader (default 32 x 16-bit vector).
module tb_value_bias_stream_loader;

  localparam int W = 16;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in [1];
  logic         data_in_valid;
  logic         data_in_ready;
  logic [W-1:0] data_out [1];
  logic         data_out_valid;
  logic         data_out_ready;
  logic         reload;
  logic         loaded;
`ifdef VALUE_BIAS_LOADER_CHECKSUM_EN
  logic [W-1:0] checksum;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model [D];
  int exp_rd;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  value_bias_stream_loader dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .reload         (reload),
`ifdef VALUE_BIAS_LOADER_CHECKSUM_EN
    .checksum       (checksum),
`endif
    .loaded         (loaded)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
    end
  endtask

  // Monitor: every output handshake pops one expected beat.
  always @(negedge clk) begin
    if (!rst && data_out_valid && data_out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat: got 0x%04h expected no beat", data_out[0]);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_out[0] !== e) begin
          bad++;
          $display("FAIL out_beat: got 0x%04h expected 0x%04h", data_out[0], e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    reload = 1'b0;
    data_in[0] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Sends D beats base..base+D-1 with 'gap' idle cycles between them.
  task automatic load_vec(input logic [W-1:0] base, input int gap);
    for (int i = 0; i < D; i++) begin
      data_in[0] = base + W'(i);
      data_in_valid = 1'b1;
      if (i == 0 || i == D - 1) begin
        check("in_ready_during_load", {15'd0, data_in_ready}, 16'd1);
        check("loaded_during_load", {15'd0, loaded}, 16'd0);
      end
      @(posedge clk); #1;
      data_in_valid = 1'b0;
      model[i] = base + W'(i);
      if (i != D - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    exp_rd = 0;
    check("in_ready_after_load", {15'd0, data_in_ready}, 16'd0);
    check("loaded_after_load", {15'd0, loaded}, 16'd1);
    check("out_valid_after_load", {15'd0, data_out_valid}, 16'd1);
    check("first_out", data_out[0], model[0]);
  endtask

  // Drives data_out_ready from 'pattern' (LSB first) for n cycles.
  task automatic replay(input int n, input logic [63:0] pattern);
    for (int k = 0; k < n; k++) begin
      data_out_ready = pattern[k];
      if (pattern[k]) begin
        exp_q.push_back(model[exp_rd]);
        exp_rd = (exp_rd + 1) % D;
      end else begin
        check("hold_while_stalled", data_out[0], model[exp_rd]);
      end
      @(posedge clk); #1;
    end
    data_out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("reset_in_ready", {15'd0, data_in_ready}, 16'd1);
    check("reset_out_valid", {15'd0, data_out_valid}, 16'd0);
    check("reset_loaded", {15'd0, loaded}, 16'd0);
`ifdef VALUE_BIAS_LOADER_CHECKSUM_EN
    check("reset_checksum", checksum, 16'h0000);
`endif

    // Basic load and replay, including wrap back to the first beat.
    load_vec(16'h0001, 0);
`ifdef VALUE_BIAS_LOADER_CHECKSUM_EN
    check("checksum_replay", checksum, 16'h0020);
`endif
    replay(34, 64'h3_FFFF_FFFF);
`ifdef VALUE_BIAS_LOADER_CHECKSUM_EN
    check("checksum_frozen", checksum, 16'h0020);
`endif

    // Output backpressure: ready 1,0,0,1,1,0,1.
    replay(7, 64'b1011001);

    // Reload coinciding with an output handshake: that beat is delivered.
    data_out_ready = 1'b1;
    reload = 1'b1;
    exp_q.push_back(model[exp_rd]);
    @(posedge clk); #1;
    reload = 1'b0;
    data_out_ready = 1'b0;
    check("reload_out_valid", {15'd0, data_out_valid}, 16'd0);
    check("reload_in_ready", {15'd0, data_in_ready}, 16'd1);
    check("reload_loaded", {15'd0, loaded}, 16'd0);
`ifdef VALUE_BIAS_LOADER_CHECKSUM_EN
    check("reload_checksum", checksum, 16'h0000);
`endif

    // Reload during LOAD drops the concurrent beat.
    data_in[0] = 16'hDEAD;
    data_in_valid = 1'b1;
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    data_in_valid = 1'b0;
    load_vec(16'h0100, 0);
    replay(33, 64'h1_FFFF_FFFF);

    // Gapped input: valid every third cycle.
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    load_vec(16'h0A00, 2);
    replay(32, 64'hFFFF_FFFF);

    // Reset in the middle of a load: a full vector is needed again.
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in[0] = 16'h0B00 + W'(i);
      data_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    do_reset();
    check("midload_rst_in_ready", {15'd0, data_in_ready}, 16'd1);
    check("midload_rst_loaded", {15'd0, loaded}, 16'd0);
    check("midload_rst_out_valid", {15'd0, data_out_valid}, 16'd0);
    load_vec(16'h0C00, 0);
    replay(5, 64'h1F);

    repeat (2) @(posedge clk);
    check("queue_drained", W'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
